// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: saturating counter helpers,
// direction-counter reset/allocate constants and the PC index/tag split.
package bp_pkg;

  // Widest value the width-generic helpers operate on.
  localparam int MAX_W = 64;

  // Direction-counter width the constants below are built for.
  localparam int CTR_W_DEFAULT = 2;

  // Weakly taken: MSB set, rest clear.
  function automatic logic [MAX_W-1:0] weak_taken(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

  // Weakly not-taken: MSB clear, rest set (0 for a 1-bit counter).
  function automatic logic [MAX_W-1:0] weak_not_taken(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  localparam logic [CTR_W_DEFAULT-1:0] CTR_WEAK_T  =
    CTR_W_DEFAULT'(weak_taken(CTR_W_DEFAULT));
  localparam logic [CTR_W_DEFAULT-1:0] CTR_WEAK_NT =
    CTR_W_DEFAULT'(weak_not_taken(CTR_W_DEFAULT));

  // Increment a w-bit value, holding at all-ones instead of wrapping.
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] val,
                                               input int w);
    logic [MAX_W-1:0] max_v;
    max_v = (MAX_W'(1) << w) - MAX_W'(1);
    return (val >= max_v) ? max_v : val + MAX_W'(1);
  endfunction

  // Decrement a w-bit value, holding at zero instead of wrapping.
  function automatic logic [MAX_W-1:0] sat_dec(input logic [MAX_W-1:0] val,
                                               input int w);
    return (val == '0) ? '0 : val - MAX_W'(1);
  endfunction

  // Table index: pc[idx_w+1:2]; the byte offset bits are ignored.
  function automatic logic [MAX_W-1:0] pc_index(input logic [MAX_W-1:0] pc,
                                                input int idx_w);
    return (pc >> 2) & ((MAX_W'(1) << idx_w) - MAX_W'(1));
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [MAX_W-1:0] pc_tag(input logic [MAX_W-1:0] pc,
                                              input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and update bundle between the fetch/decode stages and the predictor.
// Lookup is purely combinational. The update port is a valid-only push:
// every cycle with upd_valid=1 is consumed on that clock edge, there is no
// ready/backpressure.
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_mispredict;
  logic [CNT_W-1:0] mispred_cnt;

  // Pipeline side: drives lookups and resolved outcomes.
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, mispred_cnt
  );

  // Predictor side.
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target, mispred_cnt
  );
endinterface

// File: rtl/bp_sat_counter.sv
// One direction counter: async reset to weakly not-taken, load on
// allocation, otherwise saturating increment/decrement.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CTR_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(weak_not_taken(CTR_W));

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;

  // Next value: allocation load has priority over training.
  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = load_val_i;
    end else if (inc_i) begin
      ctr_d = CTR_W'(sat_inc(MAX_W'(ctr_q), CTR_W));
    end else if (dec_i) begin
      ctr_d = CTR_W'(sat_dec(MAX_W'(ctr_q), CTR_W));
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q <= RST_VAL;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational against current state (no bypass from a
// same-cycle update); updates land on the clock edge. Entry storage is kept
// in flops so the asynchronous reset can clear it.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] ALLOC_CTR = CTR_W'(weak_taken(CTR_W));

  // Entry storage.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_w    [ENTRIES];
  logic [CNT_W-1:0]   mispred_cnt_q;
  logic [CNT_W-1:0]   mispred_cnt_d;

  // Address split for both ports.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             lk_hit;
  logic             upd_hit;
  logic             upd_alloc;
  logic             upd_train_t;
  logic             upd_train_nt;

  assign lk_idx  = IDX_W'(pc_index(MAX_W'(bp.lookup_pc), IDX_W));
  assign lk_tag  = TAG_W'(pc_tag(MAX_W'(bp.lookup_pc), IDX_W));
  assign upd_idx = IDX_W'(pc_index(MAX_W'(bp.upd_pc), IDX_W));
  assign upd_tag = TAG_W'(pc_tag(MAX_W'(bp.upd_pc), IDX_W));

  // Lookup and update classification.
  always_comb begin
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_alloc    = bp.upd_valid && !upd_hit && bp.upd_taken;
    upd_train_t  = bp.upd_valid && upd_hit && bp.upd_taken;
    upd_train_nt = bp.upd_valid && upd_hit && !bp.upd_taken;
  end

  // Prediction outputs: zeroed on a miss.
  always_comb begin
    bp.pred_hit    = lk_hit;
    bp.pred_taken  = lk_hit && ctr_w[lk_idx][CTR_W-1];
    bp.pred_target = lk_hit ? target_q[lk_idx] : '0;
  end

  // One direction counter per entry; only the addressed entry is enabled.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (upd_idx == IDX_W'(i));

    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (sel && upd_alloc),
      .load_val_i (ALLOC_CTR),
      .inc_i      (sel && upd_train_t),
      .dec_i      (sel && upd_train_nt),
      .ctr_o      (ctr_w[i])
    );
  end

  // Valid/tag/target: allocate on a taken miss, retarget on a taken hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_alloc) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= bp.upd_target;
    end else if (upd_train_t) begin
      target_q[upd_idx] <= bp.upd_target;
    end
  end

  // Mispredict statistic, saturating at all-ones.
  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (bp.upd_valid && bp.upd_mispredict) begin
      mispred_cnt_d = CNT_W'(sat_inc(MAX_W'(mispred_cnt_q), CNT_W));
    end
  end

  // Statistic register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt_q <= '0;
    end else begin
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bp.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, CTR_W=2, CNT_W=4).
// Each table row is driven just after a falling edge; the row's expected
// outputs describe the state before the following rising edge applies
// that row's update.
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_predictor_if #(.XLEN(32), .CNT_W(4)) bp_if ();

  branch_predictor #(
    .XLEN(32), .ENTRIES(16), .CTR_W(2), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        ump;
    logic [31:0] lpc;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic ump,
                         input logic [31:0] lpc, input logic e_hit,
                         input logic e_taken, input logic [31:0] e_tgt,
                         input logic [3:0] e_cnt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.ump = ump;
    v.lpc = lpc; v.e_hit = e_hit; v.e_taken = e_taken; v.e_tgt = e_tgt;
    v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_hit,
                             input logic e_taken, input logic [31:0] e_tgt,
                             input logic [3:0] e_cnt);
    chk({tag, ".hit"},    32'(bp_if.pred_hit),    32'(e_hit));
    chk({tag, ".taken"},  32'(bp_if.pred_taken),  32'(e_taken));
    chk({tag, ".target"}, bp_if.pred_target,      e_tgt);
    chk({tag, ".cnt"},    32'(bp_if.mispred_cnt), 32'(e_cnt));
  endtask

  task automatic drive_upd(input logic uv, input logic [31:0] upc,
                           input logic ut, input logic [31:0] utgt,
                           input logic ump);
    bp_if.upd_valid      = uv;
    bp_if.upd_pc         = upc;
    bp_if.upd_taken      = ut;
    bp_if.upd_target     = utgt;
    bp_if.upd_mispredict = ump;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bp_if.lookup_pc = '0;
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //       uv upc           ut utgt          mp lpc           hit tk tgt          cnt
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h40,      0, 0, 32'h0,       0); // reset state
    add_vec(1, 32'h40,      1, 32'h80,      1, 32'h40,      0, 0, 32'h0,       0); // allocate
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h40,      1, 1, 32'h80,      1); // ctr 10
    add_vec(1, 32'h40,      0, 32'h0,       1, 32'h40,      1, 1, 32'h80,      1); // same-cycle: old
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h40,      1, 0, 32'h80,      2); // ctr 01
    add_vec(1, 32'h40,      0, 32'h0,       0, 32'h40,      1, 0, 32'h80,      2); // ->00
    add_vec(1, 32'h40,      1, 32'h84,      0, 32'h40,      1, 0, 32'h80,      2); // 00 ->01
    add_vec(1, 32'h40,      1, 32'h88,      0, 32'h40,      1, 0, 32'h84,      2); // 01 ->10
    add_vec(1, 32'h40,      1, 32'h88,      0, 32'h40,      1, 1, 32'h88,      2); // 10 ->11
    add_vec(1, 32'h40,      1, 32'h88,      0, 32'h40,      1, 1, 32'h88,      2); // 11 stays
    add_vec(1, 32'h40,      0, 32'h0,       0, 32'h40,      1, 1, 32'h88,      2); // 11 ->10
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h40,      1, 1, 32'h88,      2); // saturated, not wrapped
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h440,     0, 0, 32'h0,       2); // alias misses
    add_vec(1, 32'h440,     0, 32'h0,       0, 32'h40,      1, 1, 32'h88,      2); // NT miss: no change
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h40,      1, 1, 32'h88,      2);
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h440,     0, 0, 32'h0,       2);
    add_vec(1, 32'h440,     1, 32'h900,     0, 32'h440,     0, 0, 32'h0,       2); // alias allocate
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h440,     1, 1, 32'h900,     2);
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h40,      0, 0, 32'h0,       2); // evicted
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h443,     1, 1, 32'h900,     2); // pc[1:0] ignored
    add_vec(0, 32'h44,      1, 32'h44,      1, 32'h44,      0, 0, 32'h0,       2); // upd_valid=0 ignored
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h44,      0, 0, 32'h0,       2);
    add_vec(1, 32'h7C,      1, 32'h10,      0, 32'h7C,      0, 0, 32'h0,       2); // last index
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h7C,      1, 1, 32'h10,      2);
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h3C,      0, 0, 32'h0,       2); // same idx, tag 0
    add_vec(0, 32'h0,       0, 32'h0,       0, 32'h8000_0440, 0, 0, 32'h0,     2); // high tag bit

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].ump);
      bp_if.lookup_pc = vecs[i].lpc;
      #1;
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_taken,
                  vecs[i].e_tgt, vecs[i].e_cnt);
    end

    // Mispredict statistic: count is 2 here; 12 more gives 14, then saturate.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_upd(1'b1, 32'h1000, 1'b0, '0, 1'b1);
    end
    @(negedge clk);
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("cnt_after_12", 32'(bp_if.mispred_cnt), 32'd14);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_upd(1'b1, 32'h1000, 1'b0, '0, 1'b1);
    end
    @(negedge clk);
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0);
    bp_if.lookup_pc = 32'h440;
    #1;
    chk_outputs("saturated", 1'b1, 1'b1, 32'h900, 4'd15);

    // Reset between edges clears state at once; update during reset is dropped.
    #2;
    drive_upd(1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    rst = 1'b1;
    #1;
    chk_outputs("midrst_440", 1'b0, 1'b0, 32'h0, 4'd0);
    bp_if.lookup_pc = 32'h7C;
    #1;
    chk_outputs("midrst_7c", 1'b0, 1'b0, 32'h0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0);
    bp_if.lookup_pc = 32'h200;
    #1;
    chk_outputs("rst_drop_upd", 1'b0, 1'b0, 32'h0, 4'd0);

    // Normal operation resumes after reset.
    @(negedge clk);
    drive_upd(1'b1, 32'h40, 1'b1, 32'hA0, 1'b0);
    bp_if.lookup_pc = 32'h40;
    @(negedge clk);
    drive_upd(1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk_outputs("post_rst_alloc", 1'b1, 1'b1, 32'hA0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined RISC-V core. It sits beside the IF stage. Each cycle it gives a combinational taken/target prediction for the fetch PC, so the PC mux can redirect fetch instead of always fetching PC+4. Branch outcomes resolved in ID are written back through a single update port, and mispredictions are counted for performance validation.

## Interface
Parameters:
- XLEN, 32, address/data width
- ENTRIES, 16, number of BTB entries; power of two, at least 2
- CTR_W, 2, direction counter width, at least 1
- CNT_W, 16, mispredict statistics counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- lookup_pc  in  XLEN  fetch-stage PC
- pred_hit  out  1  valid entry whose tag matches lookup_pc
- pred_taken  out  1  predict taken
- pred_target  out  XLEN  predicted target; 0 when pred_hit=0
- upd_valid  in  1  resolved branch/jump update this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target, meaningful when upd_taken=1
- upd_mispredict  in  1  the prediction used for this instruction was wrong
- mispred_cnt  out  CNT_W  saturating mispredict count

## Operation
- IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Per-entry state: valid, tag, target (XLEN), ctr (CTR_W).
- Lookup (combinational):
  - pred_hit = valid[idx] && tag[idx] matches the lookup tag.
  - pred_taken = pred_hit && ctr[idx] MSB.
  - pred_target = pred_hit ? target[idx] : 0.
- Update when upd_valid=1, indexed by upd_pc:
  - Entry hit, upd_taken=1: ctr increments, saturating at all-ones; target is set to upd_target.
  - Entry hit, upd_taken=0: ctr decrements, saturating at 0; target is unchanged.
  - Entry miss, upd_taken=1: allocate the entry, overwriting any alias. Set valid=1, tag, target=upd_target, ctr = weakly taken (1 followed by CTR_W-1 zeros).
  - Entry miss, upd_taken=0: no change.
- mispred_cnt increments when upd_valid && upd_mispredict, and saturates at all-ones. upd_mispredict is ignored when upd_valid=0.
- Reset values:
  - All valid bits 0.
  - All ctr at weakly not-taken (0 followed by CTR_W-1 ones; 0 when CTR_W=1).
  - Tags and targets 0.
  - mispred_cnt 0.
  - Hence pred_hit=0, pred_taken=0, pred_target=0.

## Timing
- Lookup has zero latency: outputs are a function of lookup_pc and current state in the same cycle.
- Update has one-cycle latency: it is written on the rising edge and visible to lookups from the next cycle.
- Update and lookup to the same index in the same cycle: the lookup sees the pre-update state. There is no bypass.
- Only one update per cycle; there is no backpressure and every upd_valid is accepted.
- rst asserted mid-operation:
  - All state clears immediately, without waiting for a clock edge.
  - Outputs go to their reset values while rst is high.
  - Updates presented during reset are discarded.
- Counter arithmetic is unsigned, width CTR_W / CNT_W. Saturation is checked before wrap, so the counters never wrap.

## Structure
- Shared package bp_pkg holds:
  - functions sat_inc and sat_dec (parametrised by width);
  - the constants CTR_WEAK_T and CTR_WEAK_NT derived from CTR_W;
  - an index/tag split helper.
- Natural sub-module: bp_sat_counter. It is one CTR_W-bit saturating counter with async reset to weakly not-taken, and inc/dec enables. It is instantiated ENTRIES times via generate.
- The entry storage (valid/tag/target) stays flops, not a RAM macro, because reset must clear it asynchronously.

## Test plan
All scenarios use ENTRIES=16 and CTR_W=2 unless stated otherwise.
- Reset: hold rst, then release; lookup 0x40 -> pred_hit=0, pred_taken=0, pred_target=0, mispred_cnt=0.
- Allocate: update pc 0x40 taken with target 0x80; next cycle lookup 0x40 -> hit=1, taken=1, target 0x80 (ctr=10).
- Hysteresis: from ctr=10, not-taken update gives ctr 01 (taken=0); a second not-taken gives 00. Then three taken updates give 01, 10, 11 (taken=1 from the second). A fourth taken stays at 11.
- Aliasing: entries 0x40 and 0x440 share index 0 with different tags.
  - With 0x40 allocated, lookup 0x440 -> miss.
  - Not-taken update of 0x440 -> no change, 0x40 still hits.
  - Taken update of 0x440 to 0x900 -> 0x440 hits, 0x40 misses.
- Same-cycle: update 0x40 not-taken while looking up 0x40 in that cycle -> old prediction (taken); next cycle shows the new ctr.
- Statistics and reset mid-stream:
  - With CNT_W=4, 20 consecutive mispredicts -> mispred_cnt=15.
  - Assert rst between clock edges -> mispred_cnt=0 and all lookups miss immediately.
